alarm_ringer: RTL and testbench
===============================

Name: alarm_ringer

Overview:
- Alarm sequencer between the time/alarm comparator and the song player.
- Detects the rising edge of the time-equals-alarm match and drives the song player's play request.
- Adds keyboard snooze and dismiss, a bounded snooze count and a ring timeout.
- Runs on the 100 MHz system clock; seconds are counted from a one-cycle seconds strobe.

Parameters:
- RING_TIMEOUT_S, 60, seconds of continuous ringing before auto-stop.
- SNOOZE_S, 300, seconds of silence per snooze.
- MAX_SNOOZE, 3, snoozes allowed per alarm event.
- CNT_W, 9, seconds counter width; must hold max(RING_TIMEOUT_S, SNOOZE_S).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- sec_tick  in  1  one-cycle strobe, once per second.
- alarm_match  in  1  level, high while current time equals alarm time.
- alarm_on  in  1  alarm enable switch (level).
- snooze_key  in  1  one-cycle keypress pulse.
- dismiss_key  in  1  one-cycle keypress pulse.
- play_sound  out  1  request to song player.
- snoozing  out  1  high in SNOOZE.
- secs_left  out  CNT_W  seconds remaining in current RING or SNOOZE phase; 0 otherwise.
- snoozes_left  out  2  MAX_SNOOZE minus snoozes used.
- done_pulse  out  1  one cycle on every entry to DONE.

Behaviour:
- Reset values:
  - state=IDLE; sec_cnt=0; snooze_cnt=0; match_q=0.
  - play_sound=0, snoozing=0, secs_left=0, snoozes_left=MAX_SNOOZE, done_pulse=0.
- Edge detection: match_q registers alarm_match each cycle; rise = alarm_match & ~match_q.
- play_sound = (state==RING) and snoozing = (state==SNOOZE); both decode the state register.
- Latency: a rise sampled at edge k makes play_sound high from edge k onward (one registered step).
- Priority in RING and SNOOZE, highest first:
  - alarm_on==0
  - dismiss_key
  - snooze_key
  - sec_tick
- IDLE:
  - rise & alarm_on -> RING; sec_cnt=0; snooze_cnt=0.
  - Any rise while alarm_on==0 is discarded, with no deferred trigger.
- RING:
  - alarm_on==0 -> IDLE, with counters cleared.
  - dismiss_key -> DONE.
  - snooze_key with snooze_cnt<MAX_SNOOZE -> SNOOZE; sec_cnt=0; snooze_cnt+1.
  - snooze_key with snooze_cnt==MAX_SNOOZE -> ignored; stay in RING and keep counting.
  - sec_tick with sec_cnt==RING_TIMEOUT_S-1 -> DONE (timeout).
  - Otherwise sec_tick increments sec_cnt.
- SNOOZE:
  - alarm_on==0 -> IDLE.
  - dismiss_key -> DONE.
  - snooze_key -> ignored.
  - sec_tick with sec_cnt==SNOOZE_S-1 -> RING; sec_cnt=0.
  - Otherwise sec_tick increments sec_cnt.
- DONE:
  - Silent.
  - Stay while alarm_match==1, so the same match second cannot retrigger.
  - alarm_match==0 -> IDLE, with sec_cnt and snooze_cnt cleared.
- A rise seen while in RING, SNOOZE or DONE is ignored.
- secs_left:
  - RING: RING_TIMEOUT_S - sec_cnt.
  - SNOOZE: SNOOZE_S - sec_cnt.
  - Otherwise 0.
  - Unsigned CNT_W arithmetic; it never underflows because sec_cnt < limit.
- snoozes_left = MAX_SNOOZE - snooze_cnt. It saturates at 0.
- done_pulse is high the cycle after the transition into DONE, for exactly one cycle.
- Simultaneous events:
  - dismiss and sec_tick at timeout in the same cycle -> DONE with a single done_pulse.
  - snooze and sec_tick at timeout -> SNOOZE (snooze wins).
- Reset mid-ring forces IDLE on the next edge. play_sound drops that cycle.

Test Plan (RING_TIMEOUT_S=5, SNOOZE_S=3, MAX_SNOOZE=2; sec_tick every 10 cycles):
- Basic ring/timeout: alarm_on=1, match high 100 cycles -> play_sound high 1 cycle after first match sample; secs_left 5,4,3,2,1 on ticks; 5th tick -> DONE, done_pulse=1 once; after match low -> IDLE.
- Snooze cycle: ring, then snooze_key -> play_sound=0, snoozing=1, secs_left=3, snoozes_left=1; after 3 ticks -> RING, secs_left=5.
- Snooze exhaustion: two snoozes used, third snooze_key in RING -> ignored, play_sound stays 1, snoozes_left=0; timeout -> DONE.
- Dismiss during SNOOZE -> DONE, done_pulse once, play_sound stays 0; match still high -> stays DONE, no retrigger.
- alarm_on gating:
  - Rise with alarm_on=0 -> stays IDLE.
  - Later alarm_on=1 while match is still high -> no ring.
  - alarm_on dropped mid-RING -> IDLE next edge.
- Simultaneous/reset:
  - dismiss_key and timeout tick in the same cycle -> exactly one done_pulse.
  - reset asserted in SNOOZE -> all outputs at reset values after the edge.

Source files
------------

// File: rtl/alarm_ringer.sv
// Alarm sequencer: turns the rising edge of the time/alarm match into a play request
// for the song player, with keyboard snooze/dismiss, a snooze budget and a ring timeout.
module alarm_ringer #(
    parameter int unsigned RING_TIMEOUT_S = 60,
    parameter int unsigned SNOOZE_S       = 300,
    parameter int unsigned MAX_SNOOZE     = 3,
    parameter int unsigned CNT_W          = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sec_tick,
    input  logic             alarm_match,
    input  logic             alarm_on,
    input  logic             snooze_key,
    input  logic             dismiss_key,
    output logic             play_sound,
    output logic             snoozing,
    output logic [CNT_W-1:0] secs_left,
    output logic [1:0]       snoozes_left,
    output logic             done_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RING_LEN    = CNT_W'(RING_TIMEOUT_S);
    localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_TIMEOUT_S - 1);
    localparam logic [CNT_W-1:0] SNOOZE_LEN  = CNT_W'(SNOOZE_S);
    localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_S - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [1:0]       MAX_SN      = 2'(MAX_SNOOZE);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d;
    logic [1:0]       snooze_cnt_q, snooze_cnt_d;
    logic             match_q;
    logic             rise_s;
    logic             done_q, done_d;
    logic [CNT_W-1:0] secs_left_q, secs_left_d;
    logic [1:0]       snoozes_left_q, snoozes_left_d;

    // Remaining snoozes, clamped at zero
    function automatic logic [1:0] snz_left(input logic [1:0] used);
        if (used >= MAX_SN) begin
            return 2'd0;
        end else begin
            return MAX_SN - used;
        end
    endfunction

    assign rise_s = alarm_match & ~match_q;

    // Next-state, counter and output decode
    always_comb begin
        state_d      = state_q;
        sec_cnt_d    = sec_cnt_q;
        snooze_cnt_d = snooze_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (rise_s && alarm_on) begin
                    state_d      = ST_RING;
                    sec_cnt_d    = CNT_ZERO;
                    snooze_cnt_d = 2'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RING: begin
                if (!alarm_on) begin
                    state_d      = ST_IDLE;
                    sec_cnt_d    = CNT_ZERO;
                    snooze_cnt_d = 2'd0;
                end else if (dismiss_key) begin
                    state_d   = ST_DONE;
                    sec_cnt_d = CNT_ZERO;
                end else if (snooze_key && (snooze_cnt_q < MAX_SN)) begin
                    state_d      = ST_SNOOZE;
                    sec_cnt_d    = CNT_ZERO;
                    snooze_cnt_d = snooze_cnt_q + 2'd1;
                end else if (sec_tick) begin
                    // An exhausted snooze key lands here and the ring keeps counting
                    if (sec_cnt_q == RING_LAST) begin
                        state_d   = ST_DONE;
                        sec_cnt_d = CNT_ZERO;
                    end else begin
                        sec_cnt_d = sec_cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = ST_RING;
                end
            end
            ST_SNOOZE: begin
                if (!alarm_on) begin
                    state_d      = ST_IDLE;
                    sec_cnt_d    = CNT_ZERO;
                    snooze_cnt_d = 2'd0;
                end else if (dismiss_key) begin
                    state_d   = ST_DONE;
                    sec_cnt_d = CNT_ZERO;
                end else if (sec_tick) begin
                    if (sec_cnt_q == SNOOZE_LAST) begin
                        state_d   = ST_RING;
                        sec_cnt_d = CNT_ZERO;
                    end else begin
                        sec_cnt_d = sec_cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = ST_SNOOZE;
                end
            end
            ST_DONE: begin
                // Hold until the match second has passed so it cannot retrigger
                if (!alarm_match) begin
                    state_d      = ST_IDLE;
                    sec_cnt_d    = CNT_ZERO;
                    snooze_cnt_d = 2'd0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                sec_cnt_d    = CNT_ZERO;
                snooze_cnt_d = 2'd0;
            end
        endcase

        done_d = (state_d == ST_DONE) && (state_q != ST_DONE);

        case (state_d)
            ST_RING:   secs_left_d = RING_LEN - sec_cnt_d;
            ST_SNOOZE: secs_left_d = SNOOZE_LEN - sec_cnt_d;
            default:   secs_left_d = CNT_ZERO;
        endcase

        snoozes_left_d = snz_left(snooze_cnt_d);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            sec_cnt_q      <= CNT_ZERO;
            snooze_cnt_q   <= 2'd0;
            match_q        <= 1'b0;
            done_q         <= 1'b0;
            secs_left_q    <= CNT_ZERO;
            snoozes_left_q <= MAX_SN;
        end else begin
            state_q        <= state_d;
            sec_cnt_q      <= sec_cnt_d;
            snooze_cnt_q   <= snooze_cnt_d;
            match_q        <= alarm_match;
            done_q         <= done_d;
            secs_left_q    <= secs_left_d;
            snoozes_left_q <= snoozes_left_d;
        end
    end

    assign play_sound   = (state_q == ST_RING);
    assign snoozing     = (state_q == ST_SNOOZE);
    assign secs_left    = secs_left_q;
    assign snoozes_left = snoozes_left_q;
    assign done_pulse   = done_q;

endmodule

// File: tb/tb_alarm_ringer.sv
// Randomized plus directed bench for alarm_ringer; a countdown-style reference model
// feeds a scoreboard queue that a separate monitor drains one entry per clock.
module tb_alarm_ringer;

    localparam int RT  = 5;
    localparam int SN  = 3;
    localparam int MXS = 2;

    localparam int M_IDLE   = 0;
    localparam int M_RING   = 1;
    localparam int M_SNOOZE = 2;
    localparam int M_DONE   = 3;

    typedef struct packed {
        logic       play;
        logic       snz;
        logic [8:0] secs;
        logic [1:0] left;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sec_tick = 1'b0;
    logic       alarm_match = 1'b0;
    logic       alarm_on = 1'b0;
    logic       snooze_key = 1'b0;
    logic       dismiss_key = 1'b0;
    logic       play_sound;
    logic       snoozing;
    logic [8:0] secs_left;
    logic [1:0] snoozes_left;
    logic       done_pulse;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    int m_mode = M_IDLE;
    int m_rem = 0;
    int m_used = 0;
    bit m_prev = 1'b0;
    bit m_done = 1'b0;

    alarm_ringer #(
        .RING_TIMEOUT_S(RT),
        .SNOOZE_S(SN),
        .MAX_SNOOZE(MXS),
        .CNT_W(9)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sec_tick(sec_tick),
        .alarm_match(alarm_match),
        .alarm_on(alarm_on),
        .snooze_key(snooze_key),
        .dismiss_key(dismiss_key),
        .play_sound(play_sound),
        .snoozing(snoozing),
        .secs_left(secs_left),
        .snoozes_left(snoozes_left),
        .done_pulse(done_pulse)
    );

    always #5 clk = ~clk;

    // Reference: phases count down the seconds remaining
    task automatic model_step(input bit m, input bit on, input bit s, input bit d,
                              input bit r, input bit t);
        int old_mode;
        bit rise;
        old_mode = m_mode;
        rise = m && !m_prev;
        if (r) begin
            m_mode = M_IDLE; m_rem = 0; m_used = 0; m_prev = 1'b0; m_done = 1'b0;
            return;
        end
        case (m_mode)
            M_IDLE: if (rise && on) begin m_mode = M_RING; m_rem = RT; m_used = 0; end
            M_RING: begin
                if (!on) begin m_mode = M_IDLE; m_used = 0; end
                else if (d) m_mode = M_DONE;
                else if (s && m_used < MXS) begin m_mode = M_SNOOZE; m_rem = SN; m_used++; end
                else if (t) begin
                    if (m_rem == 1) m_mode = M_DONE;
                    else m_rem--;
                end
            end
            M_SNOOZE: begin
                if (!on) begin m_mode = M_IDLE; m_used = 0; end
                else if (d) m_mode = M_DONE;
                else if (t) begin
                    if (m_rem == 1) begin m_mode = M_RING; m_rem = RT; end
                    else m_rem--;
                end
            end
            default: if (!m) begin m_mode = M_IDLE; m_used = 0; end
        endcase
        m_done = (m_mode == M_DONE) && (old_mode != M_DONE);
        m_prev = m;
    endtask

    task automatic step(input bit m, input bit on, input bit s, input bit d,
                        input bit r, input bit x);
        exp_t e;
        bit t;
        @(negedge clk);
        t = ((cyc % 10) == 9) || x;
        alarm_match = m; alarm_on = on; snooze_key = s; dismiss_key = d;
        reset = r; sec_tick = t;
        model_step(m, on, s, d, r, t);
        e.play = (m_mode == M_RING);
        e.snz  = (m_mode == M_SNOOZE);
        e.secs = (m_mode == M_RING || m_mode == M_SNOOZE) ? 9'(m_rem) : 9'd0;
        e.left = 2'(MXS - m_used);
        e.done = m_done;
        exp_q.push_back(e);
        cyc++;
    endtask

    task automatic hold(input int n, input bit m, input bit on);
        for (int i = 0; i < n; i++) step(m, on, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Press a key on exactly the cycle that carries the ring-timeout tick
    task automatic key_at_timeout(input bit use_dismiss);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_mode == M_RING && m_rem == 1 && (cyc % 10) == 9) begin
                step(1'b1, 1'b1, !use_dismiss, use_dismiss, 1'b0, 1'b0);
                found = 1'b1;
            end else begin
                step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL timeout_window: got found=%0b want found=1", found);
        end
    endtask

    // Monitor: compare one expected entry per clock edge
    initial begin
        exp_t e;
        exp_t g;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = '{play_sound, snoozing, secs_left, snoozes_left, done_pulse};
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL outputs@%0t: got play=%0b snz=%0b secs=%0d left=%0d done=%0b want play=%0b snz=%0b secs=%0d left=%0d done=%0b",
                             $time, g.play, g.snz, g.secs, g.left, g.done,
                             e.play, e.snz, e.secs, e.left, e.done);
                end
            end
        end
    end

    initial begin
        bit rm, ron;
        // reset
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        // basic ring to timeout
        hold(100, 1'b1, 1'b1);
        hold(20, 1'b0, 1'b1);
        // snooze cycle and exhaustion
        hold(12, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        hold(40, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        hold(40, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        hold(60, 1'b1, 1'b1);
        hold(10, 1'b0, 1'b1);
        // dismiss during snooze, match stays high
        hold(5, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        hold(5, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        hold(30, 1'b1, 1'b1);
        hold(5, 1'b0, 1'b1);
        // alarm_on gating
        hold(5, 1'b0, 1'b0);
        hold(20, 1'b1, 1'b0);
        hold(20, 1'b1, 1'b1);
        hold(5, 1'b0, 1'b1);
        hold(12, 1'b1, 1'b1);
        hold(5, 1'b1, 1'b0);
        hold(5, 1'b0, 1'b1);
        // dismiss coincident with timeout tick
        hold(3, 1'b1, 1'b1);
        key_at_timeout(1'b1);
        hold(10, 1'b1, 1'b1);
        hold(5, 1'b0, 1'b1);
        // snooze coincident with timeout tick
        hold(3, 1'b1, 1'b1);
        key_at_timeout(1'b0);
        hold(10, 1'b1, 1'b1);
        // reset while snoozing
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        hold(3, 1'b0, 1'b1);
        hold(5, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        hold(5, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        hold(5, 1'b1, 1'b1);
        // randomized traffic
        rm = 1'b0;
        ron = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(39, 0) == 0) rm = !rm;
            if ($urandom_range(199, 0) == 0) ron = !ron;
            step(rm, ron, ($urandom_range(24, 0) == 0), ($urandom_range(59, 0) == 0),
                 ($urandom_range(499, 0) == 0), 1'b0);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
